// File: rtl/schnorr_pkg.sv
// ============================================================================
// schnorr_pkg : shared widths, group order and nonce FSM state encoding
// Revision    : 1.0
// ============================================================================
`default_nettype none

package schnorr_pkg;

    localparam int W_DEFAULT = 256;

    // secp256k1 group order n
    localparam logic [255:0] Q_DEFAULT =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_REDUCE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_OUT    = 3'd4,
        ST_FAIL   = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/nonce_reduce_if.sv
// ============================================================================
// nonce_reduce_if : request, PRNG and nonce handshake bundle for nonce_reduce
// Revision        : 1.0
// ============================================================================
`default_nettype none

interface nonce_reduce_if #(
    parameter int W = schnorr_pkg::W_DEFAULT
);
    logic         gen;
    logic         prng_start;
    logic [W-1:0] prng_data;
    logic         prng_valid;
    logic [W-1:0] k_out;
    logic         k_valid;
    logic         k_ready;
    logic         busy;
    logic         err;

    // slave: the nonce block itself; master: signer control, PRNG and consumer
    modport slave (
        input  gen, prng_data, prng_valid, k_ready,
        output prng_start, k_out, k_valid, busy, err
    );

    modport master (
        output gen, prng_data, prng_valid, k_ready,
        input  prng_start, k_out, k_valid, busy, err
    );
endinterface

`default_nettype wire

// File: rtl/mod_shift_sub.sv
// ============================================================================
// mod_shift_sub : one shift-subtract step of bit-serial reduction modulo q
// Revision      : 1.0
// ============================================================================
`default_nettype none

module mod_shift_sub #(
    parameter int W = schnorr_pkg::W_DEFAULT
) (
    input  wire logic [W-1:0] r,
    input  wire logic         bit_in,
    input  wire logic [W-1:0] q,
    output logic      [W-1:0] r_next
);
    logic [W-1:0] t_low;
    logic         t_ge_q;

    // t = {r, bit_in} is W+1 bits; its top bit alone already forces t >= q,
    // and since the result is < q the W-bit wrapped difference is exact.
    always_comb begin
        t_low  = {r[W-2:0], bit_in};
        t_ge_q = r[W-1] || (t_low >= q);
        r_next = t_ge_q ? (t_low - q) : t_low;
    end
endmodule

`default_nettype wire

// File: rtl/nonce_reduce.sv
// ============================================================================
// nonce_reduce : draws a PRNG word, reduces it mod Q, rejects zero, emits k
// Revision     : 1.0
// ============================================================================
`default_nettype none

module nonce_reduce
    import schnorr_pkg::*;
#(
    parameter int           W         = W_DEFAULT,
    parameter logic [W-1:0] Q         = Q_DEFAULT[W-1:0],
    parameter int           MAX_RETRY = 4
) (
    input wire logic      clk,
    input wire logic      rst_n,
    nonce_reduce_if.slave bus
);
    localparam int            CW           = $clog2(W);
    localparam int            RW           = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
    localparam logic [CW-1:0] C_BIT_LAST   = CW'(W - 1);
    localparam logic [RW-1:0] C_RETRY_LAST = RW'(MAX_RETRY - 1);

    state_t        state;
    logic [W-1:0]  d;
    logic [W-1:0]  r;
    logic [W-1:0]  r_next;
    logic [W-1:0]  k_out_q;
    logic [CW-1:0] bit_cnt;
    logic [RW-1:0] retry;
    logic          prng_start_q;
    logic          k_valid_q;
    logic          busy_q;
    logic          err_q;

    mod_shift_sub #(.W(W)) u_step (
        .r      (r),
        .bit_in (d[W-1]),
        .q      (Q),
        .r_next (r_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            d            <= '0;
            r            <= '0;
            k_out_q      <= '0;
            bit_cnt      <= '0;
            retry        <= '0;
            prng_start_q <= 1'b0;
            k_valid_q    <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    retry <= '0;
                    if (bus.gen) begin
                        prng_start_q <= 1'b1;
                        busy_q       <= 1'b1;
                        state        <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.prng_valid) begin
                        d            <= bus.prng_data;
                        r            <= '0;
                        bit_cnt      <= C_BIT_LAST;
                        prng_start_q <= 1'b0;
                        state        <= ST_REDUCE;
                    end
                end
                ST_REDUCE: begin
                    r <= r_next;
                    d <= d << 1;
                    if (bit_cnt == '0) begin
                        state <= ST_CHECK;
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (r != '0) begin
                        k_out_q   <= r;
                        k_valid_q <= 1'b1;
                        state     <= ST_OUT;
                    end else if (retry == C_RETRY_LAST) begin
                        err_q <= 1'b1;
                        state <= ST_FAIL;
                    end else begin
                        // zero is not a valid nonce: draw a fresh word
                        retry        <= retry + 1'b1;
                        prng_start_q <= 1'b1;
                        state        <= ST_WAIT;
                    end
                end
                ST_OUT: begin
                    if (bus.k_ready) begin
                        k_valid_q <= 1'b0;
                        busy_q    <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                ST_FAIL: begin
                    err_q  <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    prng_start_q <= 1'b0;
                    k_valid_q    <= 1'b0;
                    busy_q       <= 1'b0;
                    err_q        <= 1'b0;
                    state        <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.prng_start = prng_start_q;
    assign bus.k_out      = k_out_q;
    assign bus.k_valid    = k_valid_q;
    assign bus.busy       = busy_q;
    assign bus.err        = err_q;
endmodule

`default_nettype wire

// File: tb/tb_nonce_reduce.sv
// ============================================================================
// tb_nonce_reduce : directed + randomized checks of nonce_reduce at W=8 and W=256
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_nonce_reduce;
    import schnorr_pkg::*;

    localparam int             W8         = 8;
    localparam logic [7:0]     Q8         = 8'd251;
    localparam logic [255:0]   K_ALL_ONES = 256'h1_4551231950B75FC4_402DA1732FC9BEBE;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    nonce_reduce_if #(.W(W8))  b8 ();
    nonce_reduce_if #(.W(256)) bw ();

    nonce_reduce #(.W(W8), .Q(Q8), .MAX_RETRY(4)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b8)
    );

    nonce_reduce dutw (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bw)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pick8();
        case ($urandom_range(0, 3))
            0:       return 8'd0;
            1:       return Q8;
            default: return 8'($urandom);
        endcase
    endfunction

    // Act as the PRNG for one word; returns at capture + W + 1 edges.
    task automatic serve8(input logic [7:0] word, input bit poke);
        int n = 0;
        while (b8.prng_start !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("prng_start_wait", b8.prng_start, 1);
        repeat ($urandom_range(0, 2)) begin
            tick();
            check("prng_start_level", b8.prng_start, 1);
        end
        b8.prng_valid = 1'b1;
        b8.prng_data  = word;
        tick();
        b8.prng_valid = 1'b0;
        b8.prng_data  = 8'($urandom);
        check("prng_start_drop", b8.prng_start, 0);
        for (int i = 1; i <= W8; i++) begin
            if (poke && i == 4) b8.gen = 1'b1;
            if (i == 2) b8.prng_valid = 1'b1;
            tick();
            b8.gen        = 1'b0;
            b8.prng_valid = 1'b0;
        end
        check("k_valid_early", b8.k_valid, 0);
        tick();
    endtask

    // One nonce request; model: first word with nonzero (word mod Q) wins.
    task automatic nonce8(input logic [7:0] w [4], input int hold, input bit poke);
        logic [7:0] m;
        b8.gen = 1'b1;
        tick();
        b8.gen = 1'b0;
        check("busy_after_gen", b8.busy, 1);
        check("start_after_gen", b8.prng_start, 1);
        for (int i = 0; i < 4; i++) begin
            m = 8'(int'(w[i]) % int'(Q8));
            serve8(w[i], poke);
            if (m != 8'd0) begin
                check("k_valid", b8.k_valid, 1);
                check("k_out", b8.k_out, m);
                check("err_clear", b8.err, 0);
                check("no_restart", b8.prng_start, 0);
                for (int c = 0; c < hold; c++) begin
                    if (poke && c == 1) b8.gen = 1'b1;
                    tick();
                    b8.gen = 1'b0;
                    check("k_out_hold", b8.k_out, m);
                    check("k_valid_hold", b8.k_valid, 1);
                    check("no_second_req", b8.prng_start, 0);
                end
                b8.k_ready = 1'b1;
                if (poke) b8.gen = 1'b1;
                tick();
                b8.k_ready = 1'b0;
                b8.gen     = 1'b0;
                check("k_valid_drop", b8.k_valid, 0);
                check("idle_busy", b8.busy, 0);
                check("gen_with_ready_ignored", b8.prng_start, 0);
                return;
            end
            if (i < 3) begin
                check("retry_start", b8.prng_start, 1);
                check("retry_no_valid", b8.k_valid, 0);
            end else begin
                check("err_pulse", b8.err, 1);
                check("fail_no_valid", b8.k_valid, 0);
                tick();
                check("err_one_cycle", b8.err, 0);
                check("fail_busy_drop", b8.busy, 0);
                check("fail_no_valid_after", b8.k_valid, 0);
            end
        end
    endtask

    task automatic nonce256(input logic [255:0] word, input logic [255:0] exp);
        int n = 0;
        bw.gen = 1'b1;
        tick();
        bw.gen = 1'b0;
        while (bw.prng_start !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("w_start", bw.prng_start, 1);
        bw.prng_valid = 1'b1;
        bw.prng_data  = word;
        tick();
        bw.prng_valid = 1'b0;
        bw.prng_data  = '0;
        repeat (256) tick();
        check("w_k_valid_early", bw.k_valid, 0);
        tick();
        check("w_k_valid", bw.k_valid, 1);
        check("w_k_out", bw.k_out, exp);
        bw.k_ready = 1'b1;
        tick();
        bw.k_ready = 1'b0;
        check("w_idle", bw.busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0]   ws [4];
        logic [255:0] big;

        b8.gen = 1'b0; b8.prng_valid = 1'b0; b8.prng_data = '0; b8.k_ready = 1'b0;
        bw.gen = 1'b0; bw.prng_valid = 1'b0; bw.prng_data = '0; bw.k_ready = 1'b0;

        #2 rst_n = 1'b0;
        repeat (2) tick();
        check("rst_prng_start", b8.prng_start, 0);
        check("rst_k_valid", b8.k_valid, 0);
        check("rst_busy", b8.busy, 0);
        check("rst_err", b8.err, 0);
        check("rst_k_out", b8.k_out, 0);
        check("rst_w_k_out", bw.k_out, 0);
        check("rst_w_busy", bw.busy, 0);
        rst_n = 1'b1;
        tick();

        ws = '{8'd255, 8'd1, 8'd1, 8'd1};
        nonce8(ws, 0, 1'b0);
        ws = '{8'd251, 8'd7, 8'd1, 8'd1};
        nonce8(ws, 0, 1'b0);
        ws = '{8'd0, 8'd0, 8'd0, 8'd0};
        nonce8(ws, 0, 1'b0);
        ws = '{8'd200, 8'd1, 8'd1, 8'd1};
        nonce8(ws, 5, 1'b1);

        // asynchronous reset in the fourth REDUCE cycle
        b8.gen = 1'b1;
        tick();
        b8.gen        = 1'b0;
        b8.prng_valid = 1'b1;
        b8.prng_data  = 8'd55;
        tick();
        b8.prng_valid = 1'b0;
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", b8.busy, 0);
        check("midrst_prng_start", b8.prng_start, 0);
        check("midrst_k_valid", b8.k_valid, 0);
        check("midrst_err", b8.err, 0);
        check("midrst_k_out", b8.k_out, 0);
        tick();
        rst_n = 1'b1;
        tick();
        ws = '{8'd100, 8'd1, 8'd1, 8'd1};
        nonce8(ws, 1, 1'b0);

        for (int n = 0; n < 12; n++) begin
            for (int j = 0; j < 4; j++) ws[j] = pick8();
            nonce8(ws, int'($urandom_range(0, 3)), n[0]);
        end

        nonce256({256{1'b1}}, K_ALL_ONES);
        big = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        big[255:224] = 32'hFFFF_FFFF;
        nonce256(big, big % Q_DEFAULT);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

`default_nettype wire
